uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter core between two byte-stream requesters.
- Arbitrates round-robin at packet granularity and holds the grant until the owner's last byte, so packets never interleave.
- Sequences the TX core's start/busy handshake, one byte at a time.
- Releases a stalled owner after a programmable idle timeout.

---
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core between two byte requesters, round-robin per packet.
// Latency: valid in IDLE -> ready +1 cycle; capture -> tx_start +1 cycle when the core is idle.
// Backpressure: reqN_ready only in LOAD for the owner; tx_busy holds START/WAIT states.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_flag;
  // Index of the requester served most recently; the other one wins a tie.
  logic             last_served;

  logic       own_valid;
  logic [7:0] own_data;
  logic       own_last;

  // Owner mux: grant is one-hot whenever it matters (outside IDLE).
  assign own_valid = grant[1] ? req1_valid : req0_valid;
  assign own_data  = grant[1] ? req1_data  : req0_data;
  assign own_last  = grant[1] ? req1_last  : req0_last;

  // Ready is a pure decode so a byte is taken the same cycle the owner presents it.
  assign req0_ready = (state == LOAD) && grant[0] && req0_valid;
  assign req1_ready = (state == LOAD) && grant[1] && req1_valid;

  // Start pulse is tied to the START cycle in which the core reports idle.
  assign tx_start = (state == START) && !tx_busy;

  // Arbitration, byte sequencing and idle-timeout state machine.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 2'b00;
      tx_data     <= 8'h00;
      timeout     <= 1'b0;
      cnt         <= '0;
      last_flag   <= 1'b0;
      last_served <= 1'b1;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid && (!req1_valid || last_served)) begin
            grant <= 2'b01;
            state <= LOAD;
          end else if (req1_valid) begin
            grant <= 2'b10;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (own_valid) begin
            tx_data   <= own_data;
            last_flag <= own_last;
            cnt       <= '0;
            state     <= START;
          end else if (cnt == CNT_MAX) begin
            timeout     <= 1'b1;
            last_served <= grant[1];
            grant       <= 2'b00;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        START: begin
          if (!tx_busy) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              last_served <= grant[1];
              grant       <= 2'b00;
              state       <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small TX-core busy model.
// Latency: checks cycle-exact ready/start/timeout timing against hand-derived values.
// Backpressure: busy model stretches frames; a force input holds busy off START.
module tb_uart_tx_arbiter;

  logic       clock;
  logic       reset_n;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       timeout;

  logic       force_busy;
  int         bcnt;
  int         n_cmp;
  int         n_err;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(1024), .CNT_W(11)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  // TX core model: busy for four cycles starting the cycle after a start pulse.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)      bcnt <= 0;
    else if (tx_start) bcnt <= 4;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  assign tx_busy = (bcnt != 0) || force_busy;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (grant != 2'b00 && i < 40) begin
      cyc(1);
      i++;
    end
    chk(tag, {30'd0, grant}, 32'd0);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int i;
    i = 0;
    while (tx_busy != lvl && i < 40) begin
      cyc(1);
      i++;
    end
    chk(tag, {31'd0, tx_busy}, {31'd0, lvl});
  endtask

  initial begin
    int bad;
    int pulses;
    int i;
    n_cmp = 0; n_err = 0;
    clock = 0; reset_n = 0; force_busy = 0;
    req0_valid = 0; req0_data = 8'h00; req0_last = 0;
    req1_valid = 0; req1_data = 8'h00; req1_last = 0;

    // Reset state
    #2;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tmo", {31'd0, timeout}, 32'd0);
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    cyc(2);
    reset_n = 1;
    #1;

    // Single byte from req0
    req0_valid = 1; req0_data = 8'h55; req0_last = 1;
    #1;
    chk("t1_idle_rdy", {31'd0, req0_ready}, 32'd0);
    cyc(1);
    chk("t1_grant", {30'd0, grant}, 32'd1);
    chk("t1_rdy", {31'd0, req0_ready}, 32'd1);
    cyc(1);
    req0_valid = 0;
    #1;
    chk("t1_start", {31'd0, tx_start}, 32'd1);
    chk("t1_data", {24'd0, tx_data}, 32'h55);
    cyc(1);
    chk("t1_start_once", {31'd0, tx_start}, 32'd0);
    wait_idle("t1_idle");
    chk("t1_data_hold", {24'd0, tx_data}, 32'h55);

    // Fresh reset so requester 0 holds the tie
    reset_n = 0;
    cyc(1);
    reset_n = 1;
    #1;

    // Tie-break and round-robin: grants 01, 00, 10, 00, 01
    req0_valid = 1; req0_data = 8'hA1; req0_last = 1;
    req1_valid = 1; req1_data = 8'hB2; req1_last = 1;
    cyc(1);
    chk("t2_g01", {30'd0, grant}, 32'd1);
    chk("t2_rdy1_off", {31'd0, req1_ready}, 32'd0);
    cyc(1);
    req0_valid = 0;
    chk("t2_a1", {24'd0, tx_data}, 32'hA1);
    wait_idle("t2_g00a");
    cyc(1);
    chk("t2_g10", {30'd0, grant}, 32'd2);
    chk("t2_rdy1", {31'd0, req1_ready}, 32'd1);
    req0_valid = 1; req0_data = 8'h5A; req0_last = 1;
    #1;
    chk("t2_nonowner_rdy", {31'd0, req0_ready}, 32'd0);
    cyc(1);
    req1_valid = 0;
    chk("t2_b2", {24'd0, tx_data}, 32'hB2);
    wait_idle("t2_g00b");
    req1_valid = 1; req1_data = 8'hC4; req1_last = 1;
    cyc(1);
    chk("t2_g01_again", {30'd0, grant}, 32'd1);
    cyc(1);
    req0_valid = 0;
    chk("t2_5a", {24'd0, tx_data}, 32'h5A);
    wait_idle("t2_g00c");
    cyc(1);
    chk("t2_g10_again", {30'd0, grant}, 32'd2);
    cyc(1);
    req1_valid = 0;
    chk("t2_c4", {24'd0, tx_data}, 32'hC4);
    wait_idle("t2_g00d");

    // Packet lock: req0 three bytes while req1 waits
    req0_valid = 1; req0_data = 8'h10; req0_last = 0;
    req1_valid = 1; req1_data = 8'h77; req1_last = 1;
    bad = 0;
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      i = 0;
      while (!req0_ready && i < 40) begin
        if (req1_ready) bad++;
        cyc(1);
        i++;
      end
      chk("t3_rdy0", {31'd0, req0_ready}, 32'd1);
      if (req1_ready) bad++;
      cyc(1);
      chk("t3_byte", {24'd0, tx_data}, 32'h10 + k);
      if (k < 2) begin
        req0_data = 8'h11 + 8'(k);
        req0_last = (k == 1);
      end else begin
        req0_valid = 0;
      end
    end
    i = 0;
    while (grant != 2'b00 && i < 40) begin
      if (req1_ready) bad++;
      cyc(1);
      i++;
    end
    chk("t3_g00", {30'd0, grant}, 32'd0);
    chk("t3_rdy1_held", bad, 32'd0);
    cyc(1);
    chk("t3_g10", {30'd0, grant}, 32'd2);
    chk("t3_rdy1", {31'd0, req1_ready}, 32'd1);
    cyc(1);
    req1_valid = 0;
    chk("t3_77", {24'd0, tx_data}, 32'h77);
    wait_idle("t3_end");

    // Busy hold-off: busy forced high for 20 START cycles
    req0_valid = 1; req0_data = 8'h33; req0_last = 1;
    cyc(1);
    force_busy = 1;
    cyc(1);
    req0_valid = 0;
    chk("t4_data", {24'd0, tx_data}, 32'h33);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_start) pulses++;
      if (k < 19) cyc(1);
    end
    chk("t4_held", pulses, 32'd0);
    force_busy = 0;
    #1;
    chk("t4_start", {31'd0, tx_start}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (tx_start) pulses++;
    end
    chk("t4_once", pulses, 32'd0);
    wait_idle("t4_end");

    // Timeout: req0 byte without last, then stalls; req1 waits
    req0_valid = 1; req0_data = 8'h20; req0_last = 0;
    cyc(1);
    cyc(1);
    req0_valid = 0;
    req1_valid = 1; req1_data = 8'h99; req1_last = 1;
    chk("t5_data", {24'd0, tx_data}, 32'h20);
    wait_busy(1'b1, "t5_busy_hi");
    wait_busy(1'b0, "t5_busy_lo");
    cyc(1);
    // First LOAD cycle of the stalled owner; timeout lands 1024 cycles later.
    bad = 0;
    for (int k = 1; k < 1024; k++) begin
      cyc(1);
      if (timeout || grant != 2'b01 || req1_ready) bad++;
    end
    chk("t5_early", bad, 32'd0);
    cyc(1);
    chk("t5_tmo", {31'd0, timeout}, 32'd1);
    chk("t5_g00", {30'd0, grant}, 32'd0);
    cyc(1);
    chk("t5_tmo_pulse", {31'd0, timeout}, 32'd0);
    chk("t5_g10", {30'd0, grant}, 32'd2);
    chk("t5_rdy1", {31'd0, req1_ready}, 32'd1);
    cyc(1);
    req1_valid = 0;
    chk("t5_99", {24'd0, tx_data}, 32'h99);
    wait_idle("t5_end");

    // Async reset mid-frame; first serve req0 so the tie would favour req1
    req0_valid = 1; req0_data = 8'h44; req0_last = 1;
    cyc(2);
    req0_valid = 0;
    wait_idle("t6_pre");
    req0_valid = 1; req0_data = 8'h45; req0_last = 1;
    cyc(2);
    req0_valid = 0;
    wait_busy(1'b1, "t6_busy");
    cyc(1);
    chk("t6_in_frame", {30'd0, grant}, 32'd1);
    #2;
    reset_n = 0;
    #1;
    chk("t6_grant", {30'd0, grant}, 32'd0);
    chk("t6_data", {24'd0, tx_data}, 32'd0);
    chk("t6_start", {31'd0, tx_start}, 32'd0);
    chk("t6_tmo", {31'd0, timeout}, 32'd0);
    req0_valid = 1; req0_data = 8'h88; req0_last = 1;
    req1_valid = 1; req1_data = 8'h66; req1_last = 1;
    #1;
    chk("t6_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("t6_rdy1", {31'd0, req1_ready}, 32'd0);
    cyc(1);
    reset_n = 1;
    #1;
    cyc(1);
    chk("t6_tie_g01", {30'd0, grant}, 32'd1);
    chk("t6_tie_rdy0", {31'd0, req0_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
